// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: shared UART feeder FSM state encodings
package uart_tx_feeder_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH-entry byte FIFO with synchronous flush and level/full/empty flags
// Ports: clk, rst_n (async active-low), flush, wr_en/wr_data (push), rd_en (pop),
//        rd_data (head, combinational), level, empty, full.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic push, pop;
  // full blocks writes even when a pop happens in the same cycle
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level = count;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues producer bytes and issues them one at a time to the UART transmitter
// Ports: clk, rst_n (async active-low); producer wr_valid/wr_data/wr_ready, flush;
//        transmitter tx_start/tx_data (registered), tx_busy/tx_done; status level/empty/full.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          flush,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);
  feeder_state_t state, next_state;
  logic [7:0] head;
  logic pop;
  assign wr_ready = !full;
  assign pop = state == IDLE && !empty && !tx_busy;
  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );
  // start is held until busy is seen so a slow transmitter tick never loses it
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      next_state = pop ? START : IDLE;
      START:     next_state = tx_busy ? WAIT_DONE : START;
      WAIT_DONE: next_state = (tx_done || !tx_busy) ? IDLE : WAIT_DONE;
      default:   next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_start <= next_state == START;
      if (pop) tx_data <= head;
    end
endmodule
